hamming_frame_serializer: RTL and testbench
===========================================

Name: hamming_frame_serializer

Overview:
Upstream source stage for the per-line error-injection / error-correction chain. Accepts 4-bit data nibbles through a valid/ready handshake and buffers them in a small FIFO. Encodes each nibble as a Hamming(7,4) codeword and shifts it out serially on one data line, with a strobe that frames each codeword. One instance drives each routed line, so a downstream injector/corrector pair sees exactly one 7-bit frame per strobe burst.

Parameters:
FIFO_DEPTH, 4, number of buffered nibbles; power of two, 2..16
GAP_CYCLES, 1, idle cycles (strobe low) forced between consecutive frames; 0..15

Ports:
clk  input  1  system clock (divided board clock)
rst  input  1  reset; asynchronous, active-low
d_in  input  4 [1:4]  data nibble; d_in[1] = d1 ... d_in[4] = d4
d_valid  input  1  d_in holds a word to transfer
d_ready  output  1  FIFO can accept a word this cycle
data_line  output  1  serial codeword bit
strobe  output  1  high during each of the 7 bit-cycles of a frame
busy  output  1  high while a frame is shifting, in a gap, or the FIFO is non-empty
frame_count  output  8  number of completed frames; wraps modulo 256

Behaviour:
- Reset (rst=0, asynchronous):
  - data_line=0, strobe=0, busy=0, frame_count=0, d_ready=0 while asserted.
  - FIFO is emptied and the FSM goes to IDLE.
  - After release, d_ready=1 from the first clock edge.
- Handshake:
  - A write occurs on a rising edge when d_valid && d_ready.
  - d_ready = !fifo_full, taken from registered state; there is no same-cycle ready pass-through when a pop frees a slot.
  - Writes while d_ready=0 are ignored; the upstream must hold the data.
- Encoding (performed at pop):
  - p1 = d1^d2^d4, p2 = d1^d3^d4, p4 = d2^d3^d4.
  - Codeword order c1..c7 = p1 p2 d1 p4 d2 d3 d4.
  - Transmitted c1 first, one bit per clock.
- FSM: IDLE, SHIFT, GAP.
  - IDLE: if the FIFO is non-empty, pop at the next edge, load the 7-bit shift register and a bit counter of 0, assert strobe, drive data_line=c1, go to SHIFT. Otherwise strobe=0 and data_line=0.
  - SHIFT: each edge advances to the next bit.
  - SHIFT exit: on the edge after c7 has been driven, frame_count increments. If GAP_CYCLES>0, go to GAP with strobe=0 and data_line=0. If GAP_CYCLES=0 and the FIFO is non-empty, pop and load the next frame directly, keeping strobe high and back-to-back. Otherwise go to IDLE.
  - GAP: counts GAP_CYCLES cycles with strobe=0 and data_line=0, then behaves as IDLE on the next edge.
- Latency: a word written at edge k into an empty FIFO with the FSM in IDLE appears as c1 on data_line after edge k+1. c7 is on the line after edge k+7. frame_count updates at edge k+8.
- All outputs are registered; data_line and strobe change only on clock edges.
- Simultaneous write and pop:
  - Allowed in any state; occupancy stays unchanged.
  - A write into an empty FIFO while the FSM pops is impossible; an empty FIFO never pops.
- FIFO full: d_ready=0. If a pop occurs that cycle, d_ready returns to 1 after the edge.
- Wrap-around: FIFO pointers wrap modulo FIFO_DEPTH. frame_count wraps from 255 to 0.
- Reset mid-frame: the partial frame is abandoned, strobe drops immediately, and no frame_count increment occurs.

Test Plan:
1. Release reset, write 4'b1011 once -> from edge k+1, strobe high for exactly 7 cycles, data_line sequence 0,1,1,0,0,1,1; frame_count=1 at edge k+8.
2. Write 4'b0000, 4'b1111, 4'b0001 back-to-back with GAP_CYCLES=1 -> frames 0000000, 1111111, 1101001, each separated by exactly one strobe-low cycle; frame_count=3.
3. GAP_CYCLES=0, two words queued -> strobe high for 14 consecutive cycles, bit 8 = c1 of the second word, no gap.
4. Hold d_valid=1 for 10 cycles with FIFO_DEPTH=4 -> d_ready falls after 4 writes plus 1 (the first word is popped immediately), then rises one cycle after each pop; no word is lost or duplicated, in-order output.
5. Assert rst=0 at bit c4 of a frame -> strobe, data_line, busy at 0 asynchronously; after release the FIFO is empty, frame_count=0, and the next written word is transmitted intact.
6. Drive 256 single-word frames -> frame_count reads 255 then wraps to 0 at the end of the 256th frame.

Source files
------------

// File: rtl/hamming_frame_serializer_if.sv
// Nibble input handshake and serial frame output bundle for one routed line.
interface hamming_frame_serializer_if;
  logic [1:4] d_in;
  logic       d_valid;
  logic       d_ready;
  logic       data_line;
  logic       strobe;
  logic       busy;
  logic [7:0] frame_count;

  modport master (
    output d_in, d_valid,
    input  d_ready, data_line, strobe, busy, frame_count
  );

  modport slave (
    input  d_in, d_valid,
    output d_ready, data_line, strobe, busy, frame_count
  );
endinterface

// File: rtl/hamming_frame_serializer.sv
// Buffers 4-bit nibbles, encodes each as Hamming(7,4) and shifts it out
// MSB-first (c1..c7) on one line with a framing strobe.
module hamming_frame_serializer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  hamming_frame_serializer_if.slave   bus
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [3:0]    GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Codeword order c1..c7 = p1 p2 d1 p4 d2 d3 d4, c1 in bit 6.
  function automatic logic [6:0] hamming_encode(input logic [1:4] d);
    logic p1, p2, p4;
    p1 = d[1] ^ d[2] ^ d[4];
    p2 = d[1] ^ d[3] ^ d[4];
    p4 = d[2] ^ d[3] ^ d[4];
    return {p1, p2, d[1], p4, d[2], d[3], d[4]};
  endfunction

  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]    gap_cnt_q, gap_cnt_d;
  logic [6:0]    sr_q, sr_d;
  logic          data_line_q, data_line_d;
  logic          strobe_q, strobe_d;
  logic          busy_q, busy_d;
  logic          ready_q, ready_d;
  logic [7:0]    frame_count_q, frame_count_d;
  logic          wr_s, pop_s, load_s, empty_s;
  logic [6:0]    cw_s;

  assign empty_s = (count_q == CNT_ZERO);
  assign cw_s    = hamming_encode(mem_q[rd_ptr_q]);

  assign bus.d_ready     = ready_q;
  assign bus.data_line   = data_line_q;
  assign bus.strobe      = strobe_q;
  assign bus.busy        = busy_q;
  assign bus.frame_count = frame_count_q;

  // FIFO storage write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 4'b0000;
      end
    end else if (wr_s) begin
      mem_q[wr_ptr_q] <= bus.d_in;
    end
  end

  // FIFO pointers, occupancy and registered status outputs
  always_comb begin
    wr_s     = bus.d_valid & ready_q;
    wr_ptr_d = wr_s  ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop_s ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    case ({wr_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    ready_d = (count_d != CNT_FULL);
    busy_d  = (state_d != ST_IDLE) || (count_d != CNT_ZERO);
  end

  // Frame FSM next-state and serial output logic
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    sr_d          = sr_q;
    data_line_d   = data_line_q;
    strobe_d      = strobe_q;
    frame_count_d = frame_count_q;
    load_s        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        strobe_d    = 1'b0;
        data_line_d = 1'b0;
        if (!empty_s) begin
          load_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q == 3'd6) begin
          frame_count_d = frame_count_q + 8'd1;
          strobe_d      = 1'b0;
          data_line_d   = 1'b0;
          if (GAP_CYCLES > 0) begin
            state_d   = ST_GAP;
            gap_cnt_d = 4'd0;
          end else if (!empty_s) begin
            load_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          bit_cnt_d   = bit_cnt_q + 3'd1;
          sr_d        = {sr_q[5:0], 1'b0};
          data_line_d = sr_q[5];
        end
      end
      ST_GAP: begin
        strobe_d    = 1'b0;
        data_line_d = 1'b0;
        if (gap_cnt_q == GAP_LAST) begin
          if (!empty_s) begin
            load_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        strobe_d    = 1'b0;
        data_line_d = 1'b0;
      end
    endcase
    // Loading a frame overrides whatever the state chose for the line.
    if (load_s) begin
      state_d     = ST_SHIFT;
      bit_cnt_d   = 3'd0;
      sr_d        = cw_s;
      data_line_d = cw_s[6];
      strobe_d    = 1'b1;
    end else begin
      sr_d = sr_d;
    end
    pop_s = load_s;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q      <= {AW{1'b0}};
      rd_ptr_q      <= {AW{1'b0}};
      count_q       <= CNT_ZERO;
      state_q       <= ST_IDLE;
      bit_cnt_q     <= 3'd0;
      gap_cnt_q     <= 4'd0;
      sr_q          <= 7'd0;
      data_line_q   <= 1'b0;
      strobe_q      <= 1'b0;
      busy_q        <= 1'b0;
      ready_q       <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      sr_q          <= sr_d;
      data_line_q   <= data_line_d;
      strobe_q      <= strobe_d;
      busy_q        <= busy_d;
      ready_q       <= ready_d;
      frame_count_q <= frame_count_d;
    end
  end

endmodule

// File: tb/tb_hamming_frame_serializer.sv
// Directed bench: one instance with a one-cycle gap, one with back-to-back frames.
module tb_hamming_frame_serializer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  hamming_frame_serializer_if bus ();
  hamming_frame_serializer_if bus0 ();

  hamming_frame_serializer #(.FIFO_DEPTH(4), .GAP_CYCLES(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  hamming_frame_serializer #(.FIFO_DEPTH(4), .GAP_CYCLES(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  logic [6:0] cw3 [3];
  logic [6:0] exp_frm [5];
  logic [3:0] words [8];
  logic [6:0] cap [8];
  logic [6:0] acc;
  logic [6:0] cw_a, cw_b;
  logic [9:0] exp_rdy;
  logic       rdy_before, exp_stb, exp_dat;
  int         ncap, nb, wr_idx, f, b;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.d_in = 4'b0000;  bus.d_valid = 1'b0;
    bus0.d_in = 4'b0000; bus0.d_valid = 1'b0;
    tick();
    tick();
    chk1("rst_strobe", bus.strobe, 1'b0);
    chk1("rst_data", bus.data_line, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_ready", bus.d_ready, 1'b0);
    chk8("rst_fcount", bus.frame_count, 8'd0);
    rst = 1'b1;
    tick();
    chk1("ready_after_release", bus.d_ready, 1'b1);

    // 1: single word 1011 -> 0110011
    cw_a = 7'b0110011;
    bus.d_in = 4'b1011; bus.d_valid = 1'b1;
    tick();
    bus.d_valid = 1'b0;
    chk1("t1_strobe_pre", bus.strobe, 1'b0);
    chk1("t1_busy", bus.busy, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk1("t1_strobe", bus.strobe, 1'b1);
      chk1("t1_bit", bus.data_line, cw_a[6-i]);
    end
    chk8("t1_fcount_pre", bus.frame_count, 8'd0);
    tick();
    chk1("t1_strobe_end", bus.strobe, 1'b0);
    chk8("t1_fcount", bus.frame_count, 8'd1);
    tick(); tick(); tick();
    chk1("t1_idle_busy", bus.busy, 1'b0);

    // 2: three words, one-cycle gaps
    cw3[0] = 7'b0000000; cw3[1] = 7'b1111111; cw3[2] = 7'b1101001;
    bus.d_in = 4'b0000; bus.d_valid = 1'b1;
    tick();
    for (int i = 0; i < 24; i++) begin
      if (i == 0) bus.d_in = 4'b1111;
      else if (i == 1) bus.d_in = 4'b0001;
      else bus.d_valid = 1'b0;
      tick();
      f = i / 8;
      b = i % 8;
      exp_stb = (b < 7);
      exp_dat = (b < 7) ? cw3[f][6-b] : 1'b0;
      chk1("t2_strobe", bus.strobe, exp_stb);
      chk1("t2_bit", bus.data_line, exp_dat);
    end
    chk8("t2_fcount", bus.frame_count, 8'd4);

    // 3: GAP_CYCLES=0, back-to-back 1011 then 0001
    cw_a = 7'b0110011; cw_b = 7'b1101001;
    bus0.d_in = 4'b1011; bus0.d_valid = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) begin
      if (i == 0) bus0.d_in = 4'b0001;
      else bus0.d_valid = 1'b0;
      tick();
      exp_stb = (i < 14);
      exp_dat = (i < 7) ? cw_a[6-i] : ((i < 14) ? cw_b[13-i] : 1'b0);
      chk1("t3_strobe", bus0.strobe, exp_stb);
      chk1("t3_bit", bus0.data_line, exp_dat);
      if (i == 7) chk8("t3_fcount_mid", bus0.frame_count, 8'd1);
    end
    chk8("t3_fcount", bus0.frame_count, 8'd2);

    // 4: valid held 10 cycles into a depth-4 FIFO
    words[0] = 4'b0011; words[1] = 4'b0101; words[2] = 4'b0110; words[3] = 4'b1001;
    words[4] = 4'b1100; words[5] = 4'b1111; words[6] = 4'b1111; words[7] = 4'b1111;
    exp_frm[0] = 7'b1000011; exp_frm[1] = 7'b0100101; exp_frm[2] = 7'b1100110;
    exp_frm[3] = 7'b0011001; exp_frm[4] = 7'b0111100;
    exp_rdy = 10'b10_0000_1111;
    wr_idx = 0; ncap = 0; nb = 0; acc = 7'd0;
    tick();
    for (int i = 0; i < 60; i++) begin
      bus.d_valid = (i < 10);
      bus.d_in    = words[wr_idx];
      rdy_before  = (i == 0) ? 1'b1 : exp_rdy[i-1];
      tick();
      if (i < 10) begin
        chk1("t4_ready", bus.d_ready, exp_rdy[i]);
        if (rdy_before) wr_idx++;
      end
      if (bus.strobe === 1'b1) begin
        acc = {acc[5:0], bus.data_line};
        nb++;
        if (nb == 7) begin
          if (ncap < 8) cap[ncap] = acc;
          ncap++;
          nb = 0;
        end
      end
    end
    bus.d_valid = 1'b0;
    chk8("t4_nframes", 8'(ncap), 8'd5);
    for (int i = 0; i < 5; i++) begin
      chk8("t4_frame", {1'b0, cap[i]}, {1'b0, exp_frm[i]});
    end
    chk8("t4_fcount", bus.frame_count, 8'd9);
    chk1("t4_busy", bus.busy, 1'b0);

    // 5: reset asserted while c4 is on the line
    bus.d_in = 4'b1011; bus.d_valid = 1'b1;
    tick();
    bus.d_valid = 1'b0;
    tick(); tick(); tick(); tick();
    chk1("t5_strobe_c4", bus.strobe, 1'b1);
    rst = 1'b0;
    #1;
    chk1("t5_async_strobe", bus.strobe, 1'b0);
    chk1("t5_async_data", bus.data_line, 1'b0);
    chk1("t5_async_busy", bus.busy, 1'b0);
    chk8("t5_async_fcount", bus.frame_count, 8'd0);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk1("t5_ready", bus.d_ready, 1'b1);
    chk1("t5_busy_empty", bus.busy, 1'b0);
    tick();
    chk1("t5_strobe_idle", bus.strobe, 1'b0);
    cw_a = 7'b0100101;
    bus.d_in = 4'b0101; bus.d_valid = 1'b1;
    tick();
    bus.d_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk1("t5_strobe", bus.strobe, (i < 7));
      chk1("t5_bit", bus.data_line, (i < 7) ? cw_a[6-i] : 1'b0);
    end
    chk8("t5_fcount", bus.frame_count, 8'd1);

    // 6: frame_count wrap over 256 frames
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    bus.d_in = 4'b0110;
    for (int n = 0; n < 255; n++) begin
      bus.d_valid = 1'b1;
      tick();
      bus.d_valid = 1'b0;
      repeat (9) tick();
    end
    chk8("t6_fcount_255", bus.frame_count, 8'd255);
    bus.d_valid = 1'b1;
    tick();
    bus.d_valid = 1'b0;
    repeat (7) tick();
    chk1("t6_strobe_last", bus.strobe, 1'b1);
    chk8("t6_fcount_hold", bus.frame_count, 8'd255);
    tick();
    chk8("t6_fcount_wrap", bus.frame_count, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
